// File: rtl/id_lexer_pkg.sv
// Shared types and ASCII bounds for the identifier lexer.
// Holds the lexer state enum, character class enum and class boundary constants.
package id_lexer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ID_ALPHA = 2'd1,
    ID_DIGIT = 2'd2,
    NUMBER   = 2'd3
  } lex_state_t;

  typedef enum logic [1:0] {
    CLS_DELIM = 2'd0,
    CLS_ALPHA = 2'd1,
    CLS_DIGIT = 2'd2
  } char_cls_t;

  localparam logic [7:0] ASCII_UPPER_LO = 8'd65;
  localparam logic [7:0] ASCII_UPPER_HI = 8'd90;
  localparam logic [7:0] ASCII_LOWER_LO = 8'd97;
  localparam logic [7:0] ASCII_LOWER_HI = 8'd122;
  localparam logic [7:0] ASCII_DIGIT_LO = 8'd48;
  localparam logic [7:0] ASCII_DIGIT_HI = 8'd57;
  localparam logic [7:0] ASCII_USCORE   = 8'd95;

endpackage

// File: rtl/id_char_class.sv
// Combinational ASCII classifier: letter, digit or delimiter; zero latency, no flow control.
// ID_LEXER_UNDERSCORE_EN makes '_' a letter so it can start and continue identifiers.
module id_char_class
  import id_lexer_pkg::*;
(
  input  logic [7:0] char,
  output char_cls_t  cls
);

  logic is_alpha;
  logic is_digit;
  logic is_uscore;

`ifdef ID_LEXER_UNDERSCORE_EN
  assign is_uscore = (char == ASCII_USCORE);
`else
  assign is_uscore = 1'b0;
`endif

  assign is_alpha = ((char >= ASCII_UPPER_LO) && (char <= ASCII_UPPER_HI)) ||
                    ((char >= ASCII_LOWER_LO) && (char <= ASCII_LOWER_HI)) ||
                    is_uscore;
  assign is_digit = (char >= ASCII_DIGIT_LO) && (char <= ASCII_DIGIT_HI);

  always_comb begin
    cls = CLS_DELIM;
    if (is_alpha)      cls = CLS_ALPHA;
    else if (is_digit) cls = CLS_DIGIT;
  end

endmodule

// File: rtl/id_lexer.sv
// Identifier lexer over a qualified char stream; all outputs registered, 1-cycle latency.
// in_valid=0 holds all state (id_done low); no backpressure. Underscore rule: ID_LEXER_UNDERSCORE_EN.
module id_lexer
  import id_lexer_pkg::*;
#(
  parameter int MAX_LEN = 15,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       char,
  output logic             out,
  output logic             id_done,
  output logic [LEN_W-1:0] id_len,
  output logic             id_trunc,
  output logic [CNT_W-1:0] id_count
);

  // Run length is one bit wider so it can park at MAX_LEN+1 and flag truncation.
  localparam logic [LEN_W:0]   RUN_SAT = (LEN_W+1)'(MAX_LEN + 1);
  localparam logic [LEN_W:0]   RUN_MAX = (LEN_W+1)'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  lex_state_t     state;
  logic [LEN_W:0] run_len;
  logic [LEN_W:0] run_inc;
  char_cls_t      cls;

  id_char_class u_class (
    .char (char),
    .cls  (cls)
  );

  assign run_inc = (run_len == RUN_SAT) ? run_len : run_len + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run_len  <= '0;
      out      <= 1'b0;
      id_done  <= 1'b0;
      id_len   <= '0;
      id_trunc <= 1'b0;
      id_count <= '0;
    end else begin
      id_done <= 1'b0;
      if (in_valid) begin
        out <= 1'b0;
        unique case (state)
          IDLE: begin
            if (cls == CLS_ALPHA) begin
              state   <= ID_ALPHA;
              run_len <= (LEN_W+1)'(1);
            end else if (cls == CLS_DIGIT) begin
              state <= NUMBER;
            end
          end
          ID_ALPHA, ID_DIGIT: begin
            case (cls)
              CLS_ALPHA: begin
                state   <= ID_ALPHA;
                run_len <= run_inc;
              end
              CLS_DIGIT: begin
                state   <= ID_DIGIT;
                run_len <= run_inc;
                out     <= 1'b1;
              end
              default: begin
                state    <= IDLE;
                run_len  <= '0;
                id_done  <= 1'b1;
                id_len   <= (run_len > RUN_MAX) ? LEN_MAX : run_len[LEN_W-1:0];
                id_trunc <= (run_len > RUN_MAX);
                id_count <= id_count + 1'b1;
              end
            endcase
          end
          NUMBER: begin
            // Digit-led runs are literals, never identifiers.
            if (cls == CLS_DELIM) state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_lexer.sv
// Randomized and directed bench for id_lexer against a token-buffer reference model.
module tb_id_lexer;

  localparam int MAX_LEN = 15;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       char = 8'd32;
  logic             out;
  logic             id_done;
  logic [LEN_W-1:0] id_len;
  logic             id_trunc;
  logic [CNT_W-1:0] id_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the current token text plus the last reported results.
  byte unsigned     tok[$];
  bit               m_out;
  bit               m_done;
  int               m_len;
  bit               m_trunc;
  int               m_count;
  int               done_seen;

  id_lexer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .char     (char),
    .out      (out),
    .id_done  (id_done),
    .id_len   (id_len),
    .id_trunc (id_trunc),
    .id_count (id_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_alpha(input byte unsigned c);
`ifdef ID_LEXER_UNDERSCORE_EN
    if (c == 8'd95) return 1'b1;
`endif
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit m_digit(input byte unsigned c);
    return (c >= "0" && c <= "9");
  endfunction

  task automatic model_reset();
    tok.delete();
    m_out = 0; m_done = 0; m_len = 0; m_trunc = 0; m_count = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},      {31'd0, out},      {31'd0, m_out});
    chk({tag, ".id_done"},  {31'd0, id_done},  {31'd0, m_done});
    chk({tag, ".id_len"},   32'(id_len),       32'(m_len));
    chk({tag, ".id_trunc"}, {31'd0, id_trunc}, {31'd0, m_trunc});
    chk({tag, ".id_count"}, 32'(id_count),     32'(m_count % (1 << CNT_W)));
  endtask

  // One clock with the given inputs, then update the model and compare.
  task automatic step(input bit v, input byte unsigned c, input string tag);
    in_valid = v;
    char     = c;
    @(posedge clk);
    #1;
    m_done = 0;
    if (v) begin
      if (m_alpha(c) || m_digit(c)) begin
        tok.push_back(c);
        m_out = m_digit(c) && m_alpha(tok[0]);
      end else begin
        if (tok.size() > 0 && m_alpha(tok[0])) begin
          m_done  = 1;
          m_len   = (tok.size() > MAX_LEN) ? MAX_LEN : tok.size();
          m_trunc = (tok.size() > MAX_LEN);
          m_count++;
        end
        tok.delete();
        m_out = 0;
      end
    end
    if (id_done) done_seen++;
    check_all(tag);
  endtask

  task automatic feed(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  byte unsigned rc;
  int           r;

  initial begin
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // "ab1 ": out 0,0,1,0 then a 3-char identifier.
    step(1'b1, "a", "ab1_a"); chk("ab1_out_a", {31'd0, out}, 32'd0);
    step(1'b1, "b", "ab1_b"); chk("ab1_out_b", {31'd0, out}, 32'd0);
    step(1'b1, "1", "ab1_1"); chk("ab1_out_1", {31'd0, out}, 32'd1);
    step(1'b1, " ", "ab1_sp");
    chk("ab1_done", {31'd0, id_done}, 32'd1);
    chk("ab1_len", 32'(id_len), 32'd3);
    chk("ab1_cnt", 32'(id_count), 32'd1);
    step(1'b0, " ", "ab1_idle");

    // Digit-led run is never an identifier.
    do_reset();
    done_seen = 0;
    feed("9ab ", "num");
    chk("num_no_done", 32'(done_seen), 32'd0);
    chk("num_cnt", 32'(id_count), 32'd0);

    // Truncation at MAX_LEN, then a short identifier clears the flag.
    feed("abcdefghijklmnopqrst ", "trunc");
    chk("trunc_len", 32'(id_len), 32'd15);
    chk("trunc_flag", {31'd0, id_trunc}, 32'd1);
    feed("x ", "short");
    chk("short_len", 32'(id_len), 32'd1);
    chk("short_flag", {31'd0, id_trunc}, 32'd0);

    // Idle gaps hold everything.
    step(1'b1, "a", "gap_a");
    for (int i = 0; i < 5; i++) step(1'b0, "9", "gap_hold");
    step(1'b1, "2", "gap_2");
    chk("gap_out", {31'd0, out}, 32'd1);
    step(1'b1, " ", "gap_sp");
    chk("gap_len", 32'(id_len), 32'd2);

    // Open identifier discarded by reset.
    feed("abc", "rst_run");
    do_reset();
    done_seen = 0;
    step(1'b1, " ", "rst_sp");
    chk("rst_no_done", 32'(done_seen), 32'd0);
    chk("rst_cnt", 32'(id_count), 32'd0);

    // Underscore handling depends on build configuration.
    done_seen = 0;
    feed("a_b ", "usc");
`ifdef ID_LEXER_UNDERSCORE_EN
    chk("usc_dones", 32'(done_seen), 32'd1);
    chk("usc_len", 32'(id_len), 32'd3);
`else
    chk("usc_dones", 32'(done_seen), 32'd2);
    chk("usc_len", 32'(id_len), 32'd1);
`endif

    // Counter wrap.
    for (int i = 0; i < 260; i++) feed("q ", "wrap");

    // Randomized stream.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: rc = byte'($urandom_range(97, 122));
        3:       rc = byte'($urandom_range(65, 90));
        4, 5:    rc = byte'($urandom_range(48, 57));
        6:       rc = 8'd95;
        7:       rc = 8'd32;
        default: rc = byte'($urandom_range(0, 255));
      endcase
      // Occasionally let long runs build up to exercise saturation.
      if (r == 7 && $urandom_range(0, 3) == 0) rc = "z";
      step($urandom_range(0, 3) != 0, rc, "rand");
      if (i == 2000) begin
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
